fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage of the unpipelined MIPS processor.
- Holds the PC and fetches a word from instruction memory over a req/ack handshake.
- Presents the instruction fields to the control unit (opcode[31:26]) and the datapath.
- Consumes the control unit's BranchE, BranchNE and Jump, plus the ALU zero flag, to compute the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; bits[1:0] must be 0
EXEC_CYCLES, 1, cycles an instruction is held valid before PC update; minimum 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address, equal to pc
imem_ack  input  1  memory response; imem_rdata valid when high
imem_rdata  input  32  instruction word from memory
stall  input  1  freezes the execute phase (data-memory wait)
BranchE  input  1  beq decode from control
BranchNE  input  1  bne decode from control
Jump  input  1  j decode from control
alu_zero  input  1  ALU zero flag
pc  output  32  current PC
instr  output  32  latched instruction
opcode  output  6  instr[31:26], to control unit
rs, rt, rd  output  5 each  instr[25:21], [20:16], [15:11]
funct  output  6  instr[5:0]
imm  output  16  instr[15:0]
instr_valid  output  1  instr is valid and executing
retired  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, cycle counter=0, retired=0.
  - Takes effect immediately, including mid-handshake or mid-execute.
  - Any outstanding request is abandoned; a late imem_ack is ignored because imem_req is 0.
- States:
  - S_IDLE: entered only from reset. Next edge -> S_REQ with imem_req=1.
  - S_REQ: imem_req=1, imem_addr=pc. Each edge samples imem_ack.
    - ack=0: stay, unlimited wait.
    - ack=1: instr<=imem_rdata, imem_req<=0, instr_valid<=1, counter<=EXEC_CYCLES-1, -> S_EXEC.
    - Minimum fetch latency is 1 cycle (ack already high on the first S_REQ edge).
  - S_EXEC: instr_valid=1 and instr held stable.
    - stall=1: hold everything, counter frozen.
    - stall=0 and counter!=0: counter decrements.
    - stall=0 and counter==0: load pc with next PC, instr_valid<=0, imem_req<=1, -> S_REQ. retired increments on this edge.
- imem_ack while imem_req=0 is ignored. stall is ignored outside S_EXEC.
- Next-PC selection is sampled on the update edge; priority highest first:
  - Jump=1 -> {pc4[31:28], instr[25:0], 2'b00}
  - BranchE=1 and alu_zero=1 -> pc4 + (sign_ext(imm)<<2)
  - BranchNE=1 and alu_zero=0 -> pc4 + (sign_ext(imm)<<2)
  - otherwise -> pc4
- Arithmetic:
  - pc4 = pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - Branch target addition is modulo 2^32.
  - pc[1:0] is always 0.
- Simultaneous BranchE and BranchNE cannot occur from a legal decode. If they do, the priority order still applies.
- Field outputs are combinational slices of instr; they read 0 after reset (opcode 0 = R-type).
- One-instruction cadence with immediate ack and EXEC_CYCLES=1: 2 cycles per instruction (REQ, EXEC).

Optional Feature:
- Macro: FETCH_RETIRE_COUNT_EN.
- Defined:
  - retired is a 32-bit counter, incremented on each S_EXEC->S_REQ update edge.
  - Wraps 32'hFFFF_FFFF -> 0.
  - Cleared by reset.
- Undefined: retired is tied to 32'h0 and no counter flops are built.

Test Plan:
- Reset with RESET_PC=0, then ack on first request with rdata=32'h8C08_0004 -> imem_addr=0, opcode=6'b100011, rt=8, imm=4, instr_valid=1; next pc=4.
- Hold imem_ack=0 for 5 cycles -> imem_req stays 1, imem_addr constant, instr_valid=0. Ack on cycle 6 -> instr captured that edge.
- pc=0x10, instr beq with imm=16'hFFFE, BranchE=1, alu_zero=1 -> pc=0x0C. Same with alu_zero=0 -> pc=0x14. BranchNE=1 with alu_zero=0 -> pc=0x0C.
- pc=0x4000_0000, Jump=1, instr[25:0]=26'h0000100 -> pc=0x4000_0400. Jump=1 together with BranchE=1 and alu_zero=1 -> jump target wins.
- EXEC_CYCLES=3 with stall=1 for 2 cycles mid-execute -> instr_valid held for 5 cycles. pc=0xFFFF_FFFC, no branch -> pc=0.
- Assert rst low while in S_REQ -> imem_req=0 and pc=RESET_PC immediately. With FETCH_RETIRE_COUNT_EN, retired=3 after three instructions and 0 after reset; without the macro, retired=0 throughout.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch and PC-sequencing stage for an unpipelined
//               MIPS core. Fetches one word over a req/ack handshake, holds it
//               valid for EXEC_CYCLES non-stalled cycles, then selects the
//               next PC from Jump / BranchE / BranchNE / alu_zero.
// Options     : FETCH_RETIRE_COUNT_EN - builds the 32-bit retired counter;
//               when undefined, retired is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active low
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        BranchE,
  input  logic        BranchNE,
  input  logic        Jump,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic        instr_valid,
  output logic [31:0] retired
);

  // Counter only needs to hold EXEC_CYCLES-1; keep at least one bit.
  localparam int                CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
  // Word alignment is forced even if a misaligned reset vector is supplied.
  localparam logic [31:0]       PC_INIT  = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc_reg, pc_nxt;
  logic [31:0]      instr_reg, instr_nxt;
  logic             req_reg, req_nxt;
  logic             valid_reg, valid_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [31:0]      pc4;
  logic [31:0]      br_target;
  logic [31:0]      jmp_target;
  logic [31:0]      next_pc;

  assign pc4        = pc_reg + 32'd4;
  assign br_target  = pc4 + {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
  assign jmp_target = {pc4[31:28], instr_reg[25:0], 2'b00};

  // Next-PC priority: jump, then taken beq, then taken bne, else sequential.
  always_comb begin
    next_pc = pc4;
    if (Jump) begin
      next_pc = jmp_target;
    end else if (BranchE && alu_zero) begin
      next_pc = br_target;
    end else if (BranchNE && !alu_zero) begin
      next_pc = br_target;
    end
  end

  // State register plus all datapath registers owned by the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc_reg    <= PC_INIT;
      instr_reg <= 32'h0;
      req_reg   <= 1'b0;
      valid_reg <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      pc_reg    <= pc_nxt;
      instr_reg <= instr_nxt;
      req_reg   <= req_nxt;
      valid_reg <= valid_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Next-state logic: fetch handshake, execute hold/countdown, PC update.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_reg;
    instr_nxt = instr_reg;
    req_nxt   = req_reg;
    valid_nxt = valid_reg;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        req_nxt   = 1'b1;
      end
      S_REQ: begin
        if (imem_ack) begin
          instr_nxt = imem_rdata;
          req_nxt   = 1'b0;
          valid_nxt = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else begin
            pc_nxt    = next_pc;
            valid_nxt = 1'b0;
            req_nxt   = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign opcode      = instr_reg[31:26];
  assign rs          = instr_reg[25:21];
  assign rt          = instr_reg[20:16];
  assign rd          = instr_reg[15:11];
  assign funct       = instr_reg[5:0];
  assign imm         = instr_reg[15:0];

`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] retire_cnt;
  logic        retire;

  // An instruction retires on the edge that leaves S_EXEC with a PC update.
  assign retire = (state == S_EXEC) && !stall && (cnt == '0);

  // Free-running retired-instruction count, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= 32'h0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign retired = retire_cnt;
`else
  assign retired = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit. The driver plays instruction
//               memory and control, pushing one expected record per fetch;
//               the monitor pops a record on each instr_valid rise and checks
//               fields, fetch wait, retired count and execute length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          EXEC   = 3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] ret;
    int          wt;
    int          len;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        BranchE = 1'b0;
  logic        BranchNE = 1'b0;
  logic        Jump = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        instr_valid;
  logic [31:0] retired;

  entry_t sb[$];
  entry_t cur;
  int     n_vec = 0;
  int     n_err = 0;

  fetch_unit #(.RESET_PC(RST_PC), .EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .BranchE(BranchE), .BranchNE(BranchNE), .Jump(Jump),
    .alu_zero(alu_zero),
    .pc(pc), .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .funct(funct), .imm(imm), .instr_valid(instr_valid), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_ret(input logic [31:0] n);
`ifdef FETCH_RETIRE_COUNT_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: samples 1 time unit after every clock edge and on reset assertion.
  initial begin
    int  run;
    int  reqc;
    bit  prev_v;
    run = 0; reqc = 0; prev_v = 1'b0;
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (!rst) begin
        chk("rst_pc", pc, RST_PC);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", {26'h0, opcode}, 32'h0);
        chk("rst_retired", retired, 32'h0);
        run = 0; reqc = 0; prev_v = 1'b0;
      end else begin
        if (instr_valid && !prev_v) begin
          if (sb.size() == 0) begin
            chk("unexpected_fetch", 32'h1, 32'h0);
          end else begin
            cur = sb.pop_front();
            chk("pc", pc, cur.pc);
            chk("instr", instr, cur.word);
            chk("opcode", {26'h0, opcode}, {26'h0, cur.word[31:26]});
            chk("rs", {27'h0, rs}, {27'h0, cur.word[25:21]});
            chk("rt", {27'h0, rt}, {27'h0, cur.word[20:16]});
            chk("rd", {27'h0, rd}, {27'h0, cur.word[15:11]});
            chk("funct", {26'h0, funct}, {26'h0, cur.word[5:0]});
            chk("imm", {16'h0, imm}, {16'h0, cur.word[15:0]});
            chk("retired", retired, cur.ret);
            chk("req_cycles", reqc, cur.wt + 1);
            chk("req_dropped", {31'h0, imem_req}, 32'h0);
          end
          run = 1;
        end else if (instr_valid) begin
          run++;
        end else if (prev_v) begin
          chk("exec_len", run, cur.len);
        end
        if (instr_valid) reqc = 0;
        else if (imem_req) begin
          reqc++;
          if (sb.size() > 0) chk("req_addr", imem_addr, sb[0].pc);
        end
        prev_v = instr_valid;
      end
    end
  end

  task automatic fetch(input logic [31:0] epc, input logic [31:0] word, input int wt,
                       input bit j, input bit be, input bit bne, input bit z,
                       input int stl, input logic [31:0] nret);
    entry_t e;
    int guard;
    guard = 0;
    while (!imem_req) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        $display("FAIL req_timeout: imem_req never rose for pc %h", epc);
        $fatal(1);
      end
    end
    e.pc = epc; e.word = word; e.ret = exp_ret(nret); e.wt = wt; e.len = EXEC + stl;
    sb.push_back(e);
    repeat (wt) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    Jump = j; BranchE = be; BranchNE = bne; alu_zero = z;
    stall = (stl > 0);
    guard = 0;
    while (instr_valid) begin
      @(negedge clk);
      guard++;
      stall = (guard < stl);
      if (guard > 50) begin
        $display("FAIL exec_timeout: instr_valid never fell for pc %h", epc);
        $fatal(1);
      end
    end
    Jump = 1'b0; BranchE = 1'b0; BranchNE = 1'b0; alu_zero = 1'b0; stall = 1'b0;
  endtask

  // Driver: directed program with hand-computed PCs.
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    //     pc            word          wt J  BE BNE Z stl ret
    fetch(32'hFFFF_FFF8, 32'h8C08_0004, 0, 0, 0, 0, 0, 0, 0);  // lw, sequential
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 5, 0, 0, 0, 0, 0, 1);  // wraps to 0
    fetch(32'h0000_0000, 32'h0800_0004, 0, 1, 0, 0, 0, 2, 2);  // j 0x10, stalled
    fetch(32'h0000_0010, 32'h1000_FFFE, 1, 0, 1, 0, 1, 0, 3);  // beq taken
    fetch(32'h0000_000C, 32'h0800_0004, 0, 1, 0, 0, 0, 0, 4);  // j 0x10
    fetch(32'h0000_0010, 32'h1000_FFFE, 0, 0, 1, 0, 0, 0, 5);  // beq not taken
    fetch(32'h0000_0014, 32'h0800_0004, 0, 1, 0, 0, 0, 0, 6);  // j 0x10
    fetch(32'h0000_0010, 32'h1400_FFFE, 0, 0, 0, 1, 0, 0, 7);  // bne taken
    fetch(32'h0000_000C, 32'h1400_FFFE, 0, 0, 0, 1, 1, 0, 8);  // bne not taken
    fetch(32'h0000_0010, 32'h012A_4020, 0, 0, 0, 0, 0, 0, 9);  // add, -> 0x14
    // Reset while waiting in S_REQ for pc 0x14; a late ack must be ignored.
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    rst = 1'b1;
    fetch(32'hFFFF_FFF8, 32'h0800_0100, 0, 1, 1, 0, 1, 0, 0);  // jump beats beq
    fetch(32'hF000_0400, 32'h1000_FFFE, 0, 0, 1, 1, 0, 0, 1);  // beq+bne, bne wins
    fetch(32'hF000_03FC, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 2);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
